// File: rtl/cndm_proto_desc_rd_mq.sv
// cndm_proto_desc_rd_mq: round-robin multi-queue descriptor fetch engine with an ordered response FIFO
module cndm_proto_desc_rd_mq #(
   parameter int QUEUE_CNT = 4,
   parameter int DESC_SIZE = 16,
   parameter int ADDR_W = 64,
   parameter int PTR_W = 16,
   parameter int RAM_ADDR_W = 16,
   parameter int RESP_DEPTH = 8,
   localparam int QW = $clog2(QUEUE_CNT)
) (
   input  logic clk,
   input  logic rst,
   input  logic [QUEUE_CNT-1:0] q_en,
   input  logic [4*QUEUE_CNT-1:0] q_size,
   input  logic [ADDR_W*QUEUE_CNT-1:0] q_base,
   input  logic [PTR_W*QUEUE_CNT-1:0] q_prod,
   output logic [PTR_W*QUEUE_CNT-1:0] q_cons,
   input  logic [QUEUE_CNT-1:0] s_req,
   output logic [ADDR_W-1:0] dma_req_src_addr,
   output logic [RAM_ADDR_W-1:0] dma_req_dst_addr,
   output logic [$clog2(DESC_SIZE):0] dma_req_len,
   output logic [QW-1:0] dma_req_tag,
   output logic dma_req_valid,
   input  logic dma_req_ready,
   input  logic [QW-1:0] dma_sts_tag,
   input  logic [3:0] dma_sts_error,
   input  logic dma_sts_valid,
   output logic [QW-1:0] m_resp_queue,
   output logic [RAM_ADDR_W-1:0] m_resp_slot,
   output logic m_resp_empty,
   output logic m_resp_error,
   output logic m_resp_valid,
   input  logic m_resp_ready
);
   localparam int DW = $clog2(DESC_SIZE);
   localparam int FW = $clog2(RESP_DEPTH);
   typedef struct packed {
      logic [QW-1:0] q;
      logic empty;
      logic error;
   } resp_t;
   logic [QUEUE_CNT-1:0] pending_q, pending_d, inflight_q, inflight_d, gnt_oh;
   logic [QW-1:0] last_q, last_d, gq;
   logic [QUEUE_CNT-1:0][PTR_W-1:0] cons_q, cons_d;
   logic dma_valid_q, dma_valid_d;
   logic [ADDR_W-1:0] src_q, src_d, src;
   logic [RAM_ADDR_W-1:0] dst_q, dst_d;
   logic [QW-1:0] tag_q, tag_d;
   logic sts_v_q, sts_v_d, sts_err_q, sts_err_d;
   logic [QW-1:0] sts_tag_q, sts_tag_d;
   resp_t mem_q [RESP_DEPTH];
   logic [FW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FW:0] cnt_q, cnt_d;
   logic out_v_q, out_v_d;
   resp_t out_q, out_d, push_data;
   logic found, room, sel_empty, gnt, gnt_empty, gnt_fetch, push, pop;
   logic [PTR_W-1:0] mask;

   assign q_cons = cons_q;
   assign dma_req_valid = dma_valid_q;
   assign dma_req_src_addr = src_q;
   assign dma_req_dst_addr = dst_q;
   assign dma_req_tag = tag_q;
   assign dma_req_len = (DW+1)'(DESC_SIZE);
   assign m_resp_valid = out_v_q;
   assign m_resp_queue = out_q.q;
   assign m_resp_slot = RAM_ADDR_W'(out_q.q) << DW;
   assign m_resp_empty = out_q.empty;
   assign m_resp_error = out_q.error;

   // round-robin pick of the next eligible queue, grant gating and fetch address
   always_comb begin
      found = 1'b0;
      gq = '0;
      for (int i = 1; i <= QUEUE_CNT; i++) begin
         int j;
         j = (int'(last_q) + i) % QUEUE_CNT;
         if (!found && pending_q[j] && !inflight_q[j]) begin
            found = 1'b1;
            gq = QW'(j);
         end
      end
      sel_empty = !q_en[gq] || cons_q[gq] == q_prod[gq*PTR_W +: PTR_W];
      room = int'(cnt_q) + $countones(inflight_q) + int'(sts_v_q) < RESP_DEPTH;
      gnt = found && room && !(dma_valid_q && !dma_req_ready) && !(sel_empty && sts_v_q);
      gnt_empty = gnt && sel_empty;
      gnt_fetch = gnt && !sel_empty;
      gnt_oh = gnt ? QUEUE_CNT'(1) << gq : '0;
      mask = ~({PTR_W{1'b1}} << q_size[gq*4 +: 4]);
      src = q_base[gq*ADDR_W +: ADDR_W] + (ADDR_W'(cons_q[gq] & mask) << DW);
   end

   // next state for queue tracking, DMA request, completion capture and response FIFO
   always_comb begin
      sts_v_d = dma_sts_valid && inflight_q[dma_sts_tag];
      sts_tag_d = dma_sts_tag;
      sts_err_d = dma_sts_error != 4'd0;
      pending_d = (pending_q & ~gnt_oh) | s_req;
      inflight_d = (inflight_q & ~(sts_v_d ? QUEUE_CNT'(1) << dma_sts_tag : '0)) | (gnt_fetch ? gnt_oh : '0);
      last_d = gnt ? gq : last_q;
      for (int i = 0; i < QUEUE_CNT; i++)
         cons_d[i] = !q_en[i] ? '0 : cons_q[i] + PTR_W'(gnt_fetch && gq == QW'(i));
      dma_valid_d = gnt_fetch || (dma_valid_q && !dma_req_ready);
      src_d = gnt_fetch ? src : src_q;
      dst_d = gnt_fetch ? RAM_ADDR_W'(gq) << DW : dst_q;
      tag_d = gnt_fetch ? gq : tag_q;
      push = sts_v_q || gnt_empty;
      push_data = sts_v_q ? {sts_tag_q, 1'b0, sts_err_q} : {gq, 1'b1, 1'b0};
      pop = cnt_q != '0 && (!out_v_q || m_resp_ready);
      wr_d = wr_q + FW'(push);
      rd_d = rd_q + FW'(pop);
      cnt_d = cnt_q + (FW+1)'(push) - (FW+1)'(pop);
      out_v_d = pop || (out_v_q && !m_resp_ready);
      out_d = pop ? mem_q[rd_q] : out_q;
   end

   // response FIFO storage, never needs reset since the count gates reads
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_q] <= push_data;
   end

   // state registers; reset drops all tracking so late completions are ignored
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         inflight_q <= '0;
         last_q <= QW'(QUEUE_CNT - 1);
         cons_q <= '0;
         dma_valid_q <= 1'b0;
         src_q <= '0;
         dst_q <= '0;
         tag_q <= '0;
         sts_v_q <= 1'b0;
         sts_tag_q <= '0;
         sts_err_q <= 1'b0;
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
         out_v_q <= 1'b0;
         out_q <= '0;
      end else begin
         pending_q <= pending_d;
         inflight_q <= inflight_d;
         last_q <= last_d;
         cons_q <= cons_d;
         dma_valid_q <= dma_valid_d;
         src_q <= src_d;
         dst_q <= dst_d;
         tag_q <= tag_d;
         sts_v_q <= sts_v_d;
         sts_tag_q <= sts_tag_d;
         sts_err_q <= sts_err_d;
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
         out_v_q <= out_v_d;
         out_q <= out_d;
      end
   end
endmodule

// File: tb/tb_cndm_proto_desc_rd_mq.sv
// tb_cndm_proto_desc_rd_mq: directed table and sequence checks for the multi-queue descriptor reader
`timescale 1ns/1ps
module tb_cndm_proto_desc_rd_mq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] q_en = 4'hF;
   logic [15:0] q_size = '0;
   logic [255:0] q_base = '0;
   logic [63:0] q_prod = '0;
   logic [63:0] q_cons;
   logic [3:0] s_req = '0;
   logic [63:0] dma_req_src_addr;
   logic [15:0] dma_req_dst_addr;
   logic [4:0] dma_req_len;
   logic [1:0] dma_req_tag;
   logic dma_req_valid;
   logic dma_req_ready = 1'b1;
   logic [1:0] dma_sts_tag = '0;
   logic [3:0] dma_sts_error = '0;
   logic dma_sts_valid = 1'b0;
   logic [1:0] m_resp_queue;
   logic [15:0] m_resp_slot;
   logic m_resp_empty, m_resp_error, m_resp_valid;
   logic m_resp_ready = 1'b1;

   int checks = 0;
   int failures = 0;

   typedef struct { logic [1:0] tag; logic [63:0] src; logic [15:0] dst; logic [4:0] len; } dma_t;
   typedef struct { logic [1:0] q; logic [15:0] slot; logic empty; logic error; } resp_t;
   typedef struct {
      int q; logic en; logic [3:0] size; logic [63:0] base; logic [15:0] prod;
      logic empty; logic [63:0] src; logic [15:0] cons; logic [3:0] err;
   } vec_t;
   dma_t dq[$];
   resp_t rq[$];
   vec_t tbl[$];

   cndm_proto_desc_rd_mq dut (
      .clk(clk), .rst(rst), .q_en(q_en), .q_size(q_size), .q_base(q_base), .q_prod(q_prod),
      .q_cons(q_cons), .s_req(s_req), .dma_req_src_addr(dma_req_src_addr),
      .dma_req_dst_addr(dma_req_dst_addr), .dma_req_len(dma_req_len), .dma_req_tag(dma_req_tag),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_sts_tag(dma_sts_tag),
      .dma_sts_error(dma_sts_error), .dma_sts_valid(dma_sts_valid), .m_resp_queue(m_resp_queue),
      .m_resp_slot(m_resp_slot), .m_resp_empty(m_resp_empty), .m_resp_error(m_resp_error),
      .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready)
   );

   always #5 clk = ~clk;

   // log every handshake that will complete at the coming rising edge
   always @(negedge clk) begin
      if (!rst && dma_req_valid && dma_req_ready)
         dq.push_back('{dma_req_tag, dma_req_src_addr, dma_req_dst_addr, dma_req_len});
      if (!rst && m_resp_valid && m_resp_ready)
         rq.push_back('{m_resp_queue, m_resp_slot, m_resp_empty, m_resp_error});
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", n, a, e);
      end
   endtask

   task automatic wait_dma(input int n, input int lim);
      for (int i = 0; i < lim && dq.size() < n; i++) tick;
      chk("dma_count", 64'(dq.size()), 64'(n));
   endtask

   task automatic wait_resp(input int n, input int lim);
      for (int i = 0; i < lim && rq.size() < n; i++) tick;
      chk("resp_count", 64'(rq.size()), 64'(n));
   endtask

   task automatic complete(input logic [1:0] t, input logic [3:0] e);
      dma_sts_tag = t;
      dma_sts_error = e;
      dma_sts_valid = 1'b1;
      tick;
      dma_sts_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int nd, nr;
      q_en[v.q] = v.en;
      q_size[v.q*4 +: 4] = v.size;
      q_base[v.q*64 +: 64] = v.base;
      q_prod[v.q*16 +: 16] = v.prod;
      tick;
      nd = dq.size();
      nr = rq.size();
      s_req[v.q] = 1'b1;
      tick;
      s_req = '0;
      if (!v.empty) begin
         wait_dma(nd + 1, 10);
         if (dq.size() > nd) begin
            chk("vec_src", dq[nd].src, v.src);
            chk("vec_dst", 64'(dq[nd].dst), 64'(v.q * 16));
            chk("vec_tag", 64'(dq[nd].tag), 64'(v.q));
            chk("vec_len", 64'(dq[nd].len), 64'd16);
         end
         complete(2'(v.q), v.err);
      end
      wait_resp(nr + 1, 10);
      if (rq.size() > nr) begin
         chk("vec_rq", 64'(rq[nr].q), 64'(v.q));
         chk("vec_slot", 64'(rq[nr].slot), 64'(v.q * 16));
         chk("vec_empty", 64'(rq[nr].empty), 64'(v.empty));
         chk("vec_error", 64'(rq[nr].error), 64'(v.err != 4'd0));
      end
      chk("vec_cons", 64'(q_cons[v.q*16 +: 16]), 64'(v.cons));
      chk("vec_dma_total", 64'(dq.size()), 64'(nd + (v.empty ? 0 : 1)));
   endtask

   initial begin
      int nd, nr;
      tbl.push_back('{q:2, en:1, size:4, base:64'h1000, prod:1, empty:0, src:64'h1000, cons:1, err:0});
      tbl.push_back('{q:2, en:1, size:4, base:64'h1000, prod:1, empty:1, src:0, cons:1, err:0});
      tbl.push_back('{q:2, en:1, size:4, base:64'h1000, prod:2, empty:0, src:64'h1010, cons:2, err:5});
      tbl.push_back('{q:2, en:0, size:4, base:64'h1000, prod:2, empty:1, src:0, cons:0, err:0});
      tbl.push_back('{q:1, en:1, size:0, base:64'h2000, prod:3, empty:0, src:64'h2000, cons:1, err:0});
      tbl.push_back('{q:1, en:1, size:0, base:64'h2000, prod:3, empty:0, src:64'h2000, cons:2, err:0});
      tbl.push_back('{q:3, en:1, size:15, base:64'hFFFF_FFFF_FFFF_FFF0, prod:5, empty:0, src:64'hFFFF_FFFF_FFFF_FFF0, cons:1, err:0});
      tbl.push_back('{q:3, en:1, size:15, base:64'hFFFF_FFFF_FFFF_FFF0, prod:5, empty:0, src:64'h0, cons:2, err:0});
      for (int i = 0; i < 7; i++)
         tbl.push_back('{q:0, en:1, size:3, base:64'h4000, prod:9, empty:0, src:64'h4000 + 64'(i * 16), cons:16'(i + 1), err:0});
      tbl.push_back('{q:0, en:1, size:3, base:64'h4000, prod:9, empty:0, src:64'h4070, cons:8, err:0});
      tbl.push_back('{q:0, en:1, size:3, base:64'h4000, prod:9, empty:0, src:64'h4000, cons:9, err:0});
      tbl.push_back('{q:0, en:1, size:3, base:64'h4000, prod:9, empty:1, src:0, cons:9, err:0});

      repeat (3) tick;
      chk("rst_dma_valid", 64'(dma_req_valid), 64'd0);
      chk("rst_resp_valid", 64'(m_resp_valid), 64'd0);
      chk("rst_cons", q_cons, 64'd0);
      rst = 1'b0;
      tick;

      foreach (tbl[k]) run_vec(tbl[k]);

      s_req[2] = 1'b1;
      tick;
      s_req = '0;
      chk("lat_empty_e0", 64'(m_resp_valid), 64'd0);
      tick;
      chk("lat_empty_e1", 64'(m_resp_valid), 64'd0);
      tick;
      chk("lat_empty_e2", 64'(m_resp_valid), 64'd1);
      chk("lat_empty_q", 64'(m_resp_queue), 64'd2);
      chk("lat_empty_flag", 64'(m_resp_empty), 64'd1);
      tick;

      s_req[1] = 1'b1;
      tick;
      s_req = '0;
      chk("lat_dma_e0", 64'(dma_req_valid), 64'd0);
      tick;
      chk("lat_dma_e1", 64'(dma_req_valid), 64'd1);
      chk("lat_dma_src", dma_req_src_addr, 64'h2000);
      tick;
      chk("lat_dma_drop", 64'(dma_req_valid), 64'd0);
      complete(2'd1, 4'd0);
      chk("lat_cpl_e0", 64'(m_resp_valid), 64'd0);
      tick;
      chk("lat_cpl_e1", 64'(m_resp_valid), 64'd0);
      tick;
      chk("lat_cpl_e2", 64'(m_resp_valid), 64'd1);
      chk("lat_cpl_q", 64'(m_resp_queue), 64'd1);
      chk("lat_cpl_slot", 64'(m_resp_slot), 64'h10);
      chk("lat_cons1", 64'(q_cons[31:16]), 64'd3);
      tick;

      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         q_size[k*4 +: 4] = 4'd4;
         q_base[k*64 +: 64] = 64'h10000 * 64'(k + 1);
         q_prod[k*16 +: 16] = 16'd1;
      end
      q_en = 4'hF;
      #1;
      chk("rst2_cons", q_cons, 64'd0);
      tick;
      rst = 1'b0;
      tick;
      nd = dq.size();
      nr = rq.size();
      s_req = 4'hF;
      tick;
      s_req = '0;
      wait_dma(nd + 4, 12);
      for (int k = 0; k < 4; k++)
         if (dq.size() > nd + k) begin
            chk("arb_tag", 64'(dq[nd+k].tag), 64'(k));
            chk("arb_src", dq[nd+k].src, 64'h10000 * 64'(k + 1));
         end
      complete(2'd3, 4'd0);
      complete(2'd1, 4'd0);
      complete(2'd0, 4'd0);
      complete(2'd2, 4'd0);
      wait_resp(nr + 4, 12);
      for (int k = 0; k < 4; k++)
         if (rq.size() > nr + k) begin
            chk("ord_q", 64'(rq[nr+k].q), 64'(k == 0 ? 3 : k == 1 ? 1 : k == 2 ? 0 : 2));
            chk("ord_empty", 64'(rq[nr+k].empty), 64'd0);
         end

      dma_req_ready = 1'b0;
      q_prod[15:0] = 16'd2;
      q_prod[31:16] = 16'd2;
      tick;
      nd = dq.size();
      nr = rq.size();
      s_req = 4'b0011;
      tick;
      s_req = '0;
      tick;
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", 64'(dma_req_valid), 64'd1);
         chk("hold_tag", 64'(dma_req_tag), 64'd0);
         chk("hold_src", dma_req_src_addr, 64'h10010);
         chk("hold_cons1", 64'(q_cons[31:16]), 64'd1);
         tick;
      end
      dma_req_ready = 1'b1;
      wait_dma(nd + 2, 10);
      if (dq.size() > nd + 1) begin
         chk("hold_first", 64'(dq[nd].tag), 64'd0);
         chk("hold_second", 64'(dq[nd+1].tag), 64'd1);
         chk("hold_src2", dq[nd+1].src, 64'h20010);
      end
      complete(2'd0, 4'd0);
      complete(2'd1, 4'd0);
      wait_resp(nr + 2, 10);

      m_resp_ready = 1'b0;
      q_en = 4'h0;
      nd = dq.size();
      nr = rq.size();
      s_req = 4'hF;
      repeat (20) tick;
      s_req = '0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_valid", 64'(m_resp_valid), 64'd1);
         chk("bp_q", 64'(m_resp_queue), 64'd2);
         chk("bp_empty", 64'(m_resp_empty), 64'd1);
         tick;
      end
      chk("bp_no_dma", 64'(dq.size()), 64'(nd));
      m_resp_ready = 1'b1;
      wait_resp(nr + 13, 40);
      repeat (4) tick;
      chk("bp_total", 64'(rq.size()), 64'(nr + 13));
      for (int i = 0; i < 13; i++)
         if (rq.size() > nr + i) chk("bp_order", 64'(rq[nr+i].q), 64'((i + 2) % 4));

      q_en = 4'b0011;
      tick;
      nd = dq.size();
      nr = rq.size();
      s_req = 4'b0011;
      tick;
      s_req = '0;
      wait_dma(nd + 2, 10);
      m_resp_ready = 1'b0;
      s_req[3] = 1'b1;
      tick;
      s_req = '0;
      repeat (3) tick;
      chk("mid_resp_held", 64'(m_resp_valid), 64'd1);
      dma_req_ready = 1'b0;
      q_en = 4'b0111;
      s_req[2] = 1'b1;
      tick;
      s_req = '0;
      tick;
      chk("mid_dma_held", 64'(dma_req_valid), 64'd1);
      chk("mid_cons2", 64'(q_cons[47:32]), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_dma", 64'(dma_req_valid), 64'd0);
      chk("mid_rst_resp", 64'(m_resp_valid), 64'd0);
      chk("mid_rst_cons", q_cons, 64'd0);
      tick;
      rst = 1'b0;
      dma_req_ready = 1'b1;
      m_resp_ready = 1'b1;
      complete(2'd0, 4'd0);
      complete(2'd1, 4'd0);
      repeat (5) tick;
      chk("late_no_resp", 64'(rq.size()), 64'(nr));
      chk("late_resp_valid", 64'(m_resp_valid), 64'd0);
      nd = dq.size();
      s_req[0] = 1'b1;
      tick;
      s_req = '0;
      wait_dma(nd + 1, 10);
      if (dq.size() > nd) begin
         chk("post_rst_tag", 64'(dq[nd].tag), 64'd0);
         chk("post_rst_src", dq[nd].src, 64'h10000);
      end
      chk("post_rst_cons", 64'(q_cons[15:0]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
